// File: rtl/sha256_round_sequencer_pkg.sv
// Shared types, constants and round functions for the SHA-256 round sequencer.
package sha256_round_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

  // Initial hash value H0..H7, H0 in the top word.
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_const(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  // Rotate right; n is always a constant between 1 and 31.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round_sequencer_if.sv
// Block-start, message-word and digest handshake between padder, sequencer and consumer.
interface sha256_round_sequencer_if;
  logic         start;
  logic         first_block;
  logic         ready;
  logic         msg_valid;
  logic [31:0]  msg_data;
  logic         msg_ready;
  logic         hash_valid;
  logic [255:0] hash_out;

  modport master (
    output start, first_block, msg_valid, msg_data,
    input  ready, msg_ready, hash_valid, hash_out
  );

  modport slave (
    input  start, first_block, msg_valid, msg_data,
    output ready, msg_ready, hash_valid, hash_out
  );
endinterface

// File: rtl/sha256_round_sequencer_msg_schedule.sv
// 16-word circular message schedule: one write port, fixed t-2/-7/-15/-16 taps.
module sha256_round_sequencer_msg_schedule (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  idx,
  input  logic [31:0] wr_data,
  output logic [31:0] w_m2,
  output logic [31:0] w_m7,
  output logic [31:0] w_m15,
  output logic [31:0] w_m16
);

  logic [31:0] sched [16];

  // Slot t mod 16 holds W[t-16] until round t overwrites it with W[t].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) sched[i] <= '0;
    end else if (wr_en) begin
      sched[idx] <= wr_data;
    end
  end

  assign w_m2  = sched[idx - 4'd2];
  assign w_m7  = sched[idx - 4'd7];
  assign w_m15 = sched[idx - 4'd15];
  assign w_m16 = sched[idx];

endmodule

// File: rtl/sha256_round_sequencer.sv
// SHA-256 compression sequencer: one round per cycle over a streamed 16-word block.
module sha256_round_sequencer
  import sha256_round_sequencer_pkg::*;
#(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16
) (
  input logic clock,
  input logic reset,
  sha256_round_sequencer_if.slave bus
);

  localparam logic [6:0] MSG_WORDS_T = 7'(MSG_WORDS);
  localparam logic [6:0] LAST_ROUND  = 7'(ROUNDS - 1);

  state_t       state;
  logic [6:0]   t;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] hash_state;
  logic [255:0] work;
  logic [255:0] next_hash;
  logic [31:0]  w, t1, t2;
  logic [31:0]  w_m2, w_m7, w_m15, w_m16;
  logic         in_msg_phase;
  logic         advance;

  assign in_msg_phase = (t < MSG_WORDS_T);
  assign advance      = (state == ROUND) && (in_msg_phase ? bus.msg_valid : 1'b1);
  assign work         = {a, b, c, d, e, f, g, h};

  sha256_round_sequencer_msg_schedule u_sched (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (advance),
    .idx     (t[3:0]),
    .wr_data (w),
    .w_m2    (w_m2),
    .w_m7    (w_m7),
    .w_m15   (w_m15),
    .w_m16   (w_m16)
  );

  // Round datapath: W from the stream for the first 16 rounds, expanded afterwards.
  always_comb begin
    w  = in_msg_phase ? bus.msg_data
                      : small_sigma1(w_m2) + w_m7 + small_sigma0(w_m15) + w_m16;
    t1 = h + big_sigma1(e) + ch(e, f, g) + k_const(t[5:0]) + w;
    t2 = big_sigma0(a) + maj(a, b, c);
  end

  // Chaining update: each Hi plus the matching working register.
  always_comb begin
    next_hash = '0;
    for (int i = 0; i < 8; i++) begin
      next_hash[32*i +: 32] = hash_state[32*i +: 32] + work[32*i +: 32];
    end
  end

  // Control FSM with the working registers, round counter, H and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      t              <= '0;
      {a, b, c, d}   <= '0;
      {e, f, g, h}   <= '0;
      hash_state     <= '0;
      bus.ready      <= 1'b1;
      bus.msg_ready  <= 1'b0;
      bus.hash_valid <= 1'b0;
      bus.hash_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= LOAD;
            bus.ready <= 1'b0;
            if (bus.first_block) hash_state <= IV;
          end
        end
        LOAD: begin
          {a, b, c, d, e, f, g, h} <= hash_state;
          t             <= '0;
          bus.msg_ready <= 1'b1;
          state         <= ROUND;
        end
        ROUND: begin
          if (advance) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            t <= t + 7'd1;
            bus.msg_ready <= (t + 7'd1 < MSG_WORDS_T) && (t != LAST_ROUND);
            if (t == LAST_ROUND) state <= UPDATE;
          end
        end
        UPDATE: begin
          hash_state     <= next_hash;
          bus.hash_out   <= next_hash;
          bus.hash_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          bus.hash_valid <= 1'b0;
          bus.ready      <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
